// File: rtl/mmu_pkg.sv
// mmu_pkg: shared state encoding, index type and LED thermometer helper for mmu_scheduler.
package mmu_pkg;
    typedef enum logic [1:0] {TDM, RND_PICK, RND_HOLD} state_t;
    typedef logic [3:0] idx_t;
    function automatic logic [15:0] therm(input idx_t idx);
        return (16'd1 << idx) - 16'd1;
    endfunction
endpackage

// File: rtl/mmu_lfsr.sv
// mmu_lfsr: free-running 4-bit Fibonacci LFSR, period 15, synchronous reset to SEED.
module mmu_lfsr #(
    parameter logic [3:0] SEED = 4'b1101
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] q
);
    always_ff @(posedge clk)
        q <= rst ? SEED : {q[2:0], q[3] ^ q[2]};
endmodule

// File: rtl/mmu_scheduler.sv
// mmu_scheduler: TDM / random work-conserving arbiter sharing one W-bit output stream among N requesters.
module mmu_scheduler
    import mmu_pkg::*;
#(
    parameter int         N         = 4,
    parameter int         W         = 64,
    parameter int         SLICE     = 10_000_000,
    parameter logic [3:0] LFSR_SEED = 4'b1101
) (
    input  logic           D_CLK,
    input  logic           D_RST,
    input  logic           D_OFF,
    input  logic [N-1:0]   REQ,
    input  logic [N*W-1:0] DATA,
    output logic [N-1:0]   ACK,
    output logic [W-1:0]   OUT,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [N-1:0]   GNT,
    output logic [N-2:0]   LED
);
    localparam int LG = $clog2(N);
    localparam int CW = $clog2(SLICE);

    state_t        state, state_n;
    logic [LG-1:0] idx, idx_n, base, pick, j;
    logic [CW-1:0] cnt, cnt_n;
    logic          gon, gon_n, last, ld, hit;
    logic [3:0]    lfsr;
    logic [15:0]   th;

    mmu_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(D_CLK), .rst(D_RST), .q(lfsr));

    assign base = lfsr[LG-1:0];
    assign last = cnt == CW'(SLICE - 1);
    assign ld   = !OUT_VALID | OUT_READY;
    assign th   = therm(idx_t'(idx));
    assign GNT  = gon ? N'(1) << idx : '0;
    assign LED  = gon ? th[N-2:0] : '0;
    assign hit  = |(GNT & REQ);
    assign ACK  = ld ? GNT & REQ : '0;

    // Descending scan so the requester closest after base wins.
    always_comb begin
        pick = base;
        j = base;
        for (int k = N - 1; k >= 0; k--) begin
            j = base + LG'(k);
            if (REQ[j]) pick = j;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = last ? '0 : cnt + 1'b1;
        gon_n   = gon;
        case (state)
            TDM: if (last) begin
                if (D_OFF) begin
                    state_n = RND_PICK;
                    gon_n   = 1'b0;
                end else
                    idx_n = idx + 1'b1;
            end
            RND_PICK: begin
                cnt_n = '0;
                if (!D_OFF) begin
                    state_n = TDM;
                    idx_n   = '0;
                    gon_n   = 1'b1;
                end else if (|REQ) begin
                    state_n = RND_HOLD;
                    idx_n   = pick;
                    gon_n   = 1'b1;
                end
            end
            RND_HOLD: if (last || !REQ[idx]) begin
                cnt_n   = '0;
                idx_n   = '0;
                gon_n   = !D_OFF;
                state_n = D_OFF ? RND_PICK : TDM;
            end
            default: state_n = TDM;
        endcase
    end

    always_ff @(posedge D_CLK) begin
        if (D_RST) begin
            state     <= TDM;
            idx       <= '0;
            cnt       <= '0;
            gon       <= 1'b1;
            OUT       <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
            gon   <= gon_n;
            if (ld) begin
                OUT_VALID <= hit;
                if (hit) OUT <= DATA[idx*W +: W];
            end
        end
    end
endmodule

// File: tb/tb_mmu_scheduler.sv
// tb_mmu_scheduler: table-driven TDM check plus a rule-level reference model for random and corner sequences.
module tb_mmu_scheduler;
    logic         clk = 1'b0;
    logic         rst, off, ready;
    logic [3:0]   req, ack, gnt;
    logic [255:0] data;
    logic [63:0]  out;
    logic         ov;
    logic [2:0]   led;
    int           n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    mmu_scheduler #(.N(4), .W(64), .SLICE(4), .LFSR_SEED(4'b1101)) dut (
        .D_CLK(clk), .D_RST(rst), .D_OFF(off), .REQ(req), .DATA(data), .ACK(ack),
        .OUT(out), .OUT_VALID(ov), .OUT_READY(ready), .GNT(gnt), .LED(led)
    );

    // Reference model: mode 0 = deterministic slots, 1 = waiting for a pick, 2 = holding a random grant.
    int          m_mode, m_idx, m_cnt, m_gon, m_lfsr, m_ov;
    logic [63:0] m_out;

    function automatic void m_reset();
        m_mode = 0; m_idx = 0; m_cnt = 0; m_gon = 1; m_lfsr = 13; m_ov = 0; m_out = '0;
    endfunction

    function automatic void m_step();
        int g, base;
        bit hitv;
        if (rst) begin
            m_reset();
            return;
        end
        g = m_gon ? (1 << m_idx) : 0;
        hitv = (g & int'(req)) != 0;
        if (!m_ov || ready) begin
            if (hitv) m_out = data[m_idx*64 +: 64];
            m_ov = hitv;
        end
        if (m_mode == 0) begin
            if (m_cnt == 3) begin
                m_cnt = 0;
                if (off) begin m_mode = 1; m_gon = 0; end
                else m_idx = (m_idx + 1) % 4;
            end else m_cnt++;
        end else if (m_mode == 1) begin
            if (!off) begin m_mode = 0; m_idx = 0; m_cnt = 0; m_gon = 1; end
            else if (req != 0) begin
                base = m_lfsr % 4;
                for (int k = 0; k < 4; k++)
                    if (req[(base + k) % 4]) begin m_idx = (base + k) % 4; break; end
                m_mode = 2; m_cnt = 0; m_gon = 1;
            end
        end else begin
            if (m_cnt == 3 || !req[m_idx]) begin
                m_cnt = 0;
                if (off) begin m_mode = 1; m_gon = 0; end
                else begin m_mode = 0; m_idx = 0; m_gon = 1; end
            end else m_cnt++;
        end
        m_lfsr = ((m_lfsr << 1) & 15) | (((m_lfsr >> 3) ^ (m_lfsr >> 2)) & 1);
    endfunction

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    task automatic check(string tag);
        logic [3:0] g;
        logic [2:0] l;
        bit ldv;
        g = m_gon ? 4'(1 << m_idx) : 4'd0;
        l = m_gon ? 3'((1 << m_idx) - 1) : 3'd0;
        ldv = !m_ov || ready;
        chk({tag, "/gnt"}, 64'(gnt), 64'(g));
        chk({tag, "/led"}, 64'(led), 64'(l));
        chk({tag, "/ack"}, 64'(ack), ldv ? 64'(g & req) : 64'd0);
        chk({tag, "/ovalid"}, 64'(ov), 64'(m_ov));
        chk({tag, "/out"}, out, m_out);
    endtask

    task automatic tick(bit en, string tag);
        for (int i = 0; i < 8; i++) data[i*32 +: 32] = $urandom;
        @(negedge clk);
        if (en) check(tag);
        m_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [2:0] led;
        logic       ov;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int acks, guard;
        tbl = '{
            '{4'hF, 4'h1, 3'd0, 1'b0}, '{4'hF, 4'h1, 3'd0, 1'b1}, '{4'hF, 4'h1, 3'd0, 1'b1}, '{4'hF, 4'h1, 3'd0, 1'b1},
            '{4'hF, 4'h2, 3'd1, 1'b1}, '{4'hF, 4'h2, 3'd1, 1'b1}, '{4'hF, 4'h2, 3'd1, 1'b1}, '{4'hF, 4'h2, 3'd1, 1'b1},
            '{4'hF, 4'h4, 3'd3, 1'b1}, '{4'hF, 4'h4, 3'd3, 1'b1}, '{4'hF, 4'h4, 3'd3, 1'b1}, '{4'hF, 4'h4, 3'd3, 1'b1},
            '{4'hF, 4'h8, 3'd7, 1'b1}, '{4'hF, 4'h8, 3'd7, 1'b1}, '{4'hF, 4'h8, 3'd7, 1'b1}, '{4'hF, 4'h8, 3'd7, 1'b1},
            '{4'hF, 4'h1, 3'd0, 1'b1}
        };
        rst = 1'b1; off = 1'b0; req = '0; ready = 1'b1; data = '0;
        m_reset();
        @(posedge clk); #1;
        tick(0, "rst"); tick(0, "rst");
        rst = 1'b0;

        // Deterministic rotation with everyone requesting.
        for (int i = 0; i < 17; i++) begin
            req = tbl[i].req;
            #2;
            chk($sformatf("tbl%0d/gnt", i), 64'(gnt), 64'(tbl[i].gnt));
            chk($sformatf("tbl%0d/led", i), 64'(led), 64'(tbl[i].led));
            chk($sformatf("tbl%0d/ovalid", i), 64'(ov), 64'(tbl[i].ov));
            tick(1, "tdm");
        end

        // Only requester 2 active: grant still rotates, ACK only in slot 2.
        req = 4'b0100; acks = 0;
        for (int i = 0; i < 16; i++) begin
            #2;
            if (ack != 0) begin
                acks++;
                chk("sparse/ack_onehot", 64'(ack), 64'h4);
            end
            tick(1, "sparse");
        end
        chk("sparse/ack_count", 64'(acks), 64'd4);

        // Backpressure during slot 1.
        req = 4'hF;
        guard = 0;
        while (!(m_mode == 0 && m_idx == 1 && m_cnt == 0) && guard < 20) begin tick(1, "align1"); guard++; end
        chk("align1/reached", 64'(guard < 20), 64'd1);
        tick(1, "bp");
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("bp/ack_zero", 64'(ack), 64'd0);
            tick(1, "bp");
        end
        ready = 1'b1;
        tick(1, "bp");

        // Switch to random mode mid-slot 0.
        guard = 0;
        while (!(m_mode == 0 && m_idx == 0 && m_cnt == 1) && guard < 20) begin tick(1, "align0"); guard++; end
        chk("align0/reached", 64'(guard < 20), 64'd1);
        off = 1'b1;
        tick(1, "off"); tick(1, "off");
        #2 chk("off/still_slot0", 64'(gnt), 64'h1);
        tick(1, "off");
        #2 chk("pick/gap", 64'(gnt), 64'h0);
        tick(1, "pick");

        // Early release when the granted requester drops.
        tick(1, "hold");
        req = 4'hF & ~4'(1 << m_idx);
        tick(1, "drop");
        #2 chk("drop/gnt_zero", 64'(gnt), 64'h0);
        req = 4'h0;
        for (int i = 0; i < 3; i++) begin
            tick(1, "idle");
            chk("idle/gnt_zero", 64'(gnt), 64'h0);
        end

        // Reset in the middle of a random hold with data in flight.
        req = 4'hF;
        tick(1, "pick2"); tick(1, "hold2"); tick(1, "hold2");
        chk("hold2/ovalid", 64'(ov), 64'd1);
        rst = 1'b1;
        tick(1, "rst2");
        rst = 1'b0;
        chk("rst2/gnt", 64'(gnt), 64'h1);
        chk("rst2/ovalid", 64'(ov), 64'd0);
        chk("rst2/led", 64'(led), 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            req = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 40) == 0) off = ~off;
            rst = $urandom_range(0, 300) == 0;
            tick(1, "rnd");
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
